// File: rtl/sysid_read_checker_if.sv
// rtl/sysid_read_checker_if.sv - Avalon-MM read bus between the checker and the sysid slave
interface sysid_read_checker_if;
  logic        address;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address,
    output read,
    input  waitrequest,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    output waitrequest,
    output readdata
  );
endinterface

// File: rtl/sysid_read_checker.sv
// rtl/sysid_read_checker.sv - reads sysid words 0/1 and compares them with build-time values
module sysid_read_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5923_F616,
  parameter int unsigned READ_LATENCY       = 0,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  sysid_read_checker_if.master avm,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 id_ok,
  output logic                 ts_ok,
  output logic                 timeout,
  output logic [31:0]          id_value,
  output logic [31:0]          ts_value
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_LAT_ID,
    S_RD_TS,
    S_LAT_TS,
    S_CMP,
    S_DONE
  } state_t;

  // Capture happens when the latency counter equals this; counter is 1 on the cycle after accept.
  localparam logic [2:0]  LAT_TARGET = 3'(READ_LATENCY);
  localparam logic [16:0] TMO_LIMIT  = 17'(TIMEOUT_CYCLES);

  state_t      state;
  state_t      state_next;
  logic [2:0]  lat_cnt;
  logic [15:0] tmo_cnt;
  logic        tmo_hit;
  logic        start_go;
  logic        accept;
  logic        capture;
  logic        abort;
  logic        id_phase;

  // tmo_cnt holds cycles already spent, so the current cycle is number tmo_cnt+1.
  assign tmo_hit  = ({1'b0, tmo_cnt} + 17'd1) >= TMO_LIMIT;
  assign id_phase = (state == S_RD_ID) || (state == S_LAT_ID);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and bus strobes; accept and capture take priority over timeout.
  always_comb begin
    state_next  = state;
    avm.read    = 1'b0;
    avm.address = 1'b0;
    start_go    = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    abort       = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          start_go   = 1'b1;
          state_next = S_RD_ID;
        end
      end
      S_RD_ID, S_RD_TS: begin
        avm.read    = 1'b1;
        avm.address = (state == S_RD_TS);
        if (!avm.waitrequest) begin
          accept = 1'b1;
          if (READ_LATENCY == 0) begin
            capture    = 1'b1;
            state_next = (state == S_RD_ID) ? S_RD_TS : S_CMP;
          end else begin
            state_next = (state == S_RD_ID) ? S_LAT_ID : S_LAT_TS;
          end
        end else if (tmo_hit) begin
          abort      = 1'b1;
          state_next = S_DONE;
        end
      end
      S_LAT_ID, S_LAT_TS: begin
        avm.address = (state == S_LAT_TS);
        if (lat_cnt == LAT_TARGET) begin
          capture    = 1'b1;
          state_next = (state == S_LAT_ID) ? S_RD_TS : S_CMP;
        end else if (tmo_hit) begin
          abort      = 1'b1;
          state_next = S_DONE;
        end
      end
      S_CMP: begin
        state_next = S_DONE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Per-transaction timeout and read-latency counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_cnt <= '0;
      lat_cnt <= '0;
    end else begin
      if (start_go || (capture && id_phase)) begin
        tmo_cnt <= '0;
      end else if ((state == S_RD_ID) || (state == S_LAT_ID) ||
                   (state == S_RD_TS) || (state == S_LAT_TS)) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
      if (accept) begin
        lat_cnt <= 3'd1;
      end else if ((state == S_LAT_ID) || (state == S_LAT_TS)) begin
        lat_cnt <= lat_cnt + 3'd1;
      end
    end
  end

  // Captured words, result flags and status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      if (start_go) begin
        busy     <= 1'b1;
        done     <= 1'b0;
        pass     <= 1'b0;
        id_ok    <= 1'b0;
        ts_ok    <= 1'b0;
        timeout  <= 1'b0;
        id_value <= '0;
        ts_value <= '0;
      end
      if (capture) begin
        if (id_phase) begin
          id_value <= avm.readdata;
        end else begin
          ts_value <= avm.readdata;
        end
      end
      if (abort) begin
        timeout <= 1'b1;
        busy    <= 1'b0;
        done    <= 1'b1;
      end
      if (state == S_CMP) begin
        id_ok <= (id_value == EXPECTED_ID);
        ts_ok <= (ts_value == EXPECTED_TIMESTAMP);
        pass  <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TIMESTAMP);
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sysid_read_checker.sv
// tb/tb_sysid_read_checker.sv - directed self-checking bench for sysid_read_checker
module tb_sysid_read_checker;

  localparam logic [31:0] TS_GOOD = 32'h5923_F616;
  localparam logic [31:0] GARBAGE = 32'hDEAD_BEEF;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  // Instance 0: default parameters, stall controlled by wr0.
  sysid_read_checker_if bus0 ();
  logic        start0 = 1'b0;
  logic        wr0 = 1'b0;
  logic [31:0] ts_word0 = TS_GOOD;
  logic        busy0, done0, pass0, idok0, tsok0, tmo0;
  logic [31:0] idv0, tsv0;
  assign bus0.waitrequest = wr0;
  assign bus0.readdata    = bus0.address ? ts_word0 : 32'h0;

  sysid_read_checker u0 (
    .clock(clock), .reset(reset), .start(start0), .avm(bus0),
    .busy(busy0), .done(done0), .pass(pass0), .id_ok(idok0), .ts_ok(tsok0),
    .timeout(tmo0), .id_value(idv0), .ts_value(tsv0)
  );

  // Instance L: READ_LATENCY=2, data valid only two cycles after accept.
  sysid_read_checker_if busl ();
  logic        startl = 1'b0;
  logic        busyl, donel, passl, idokl, tsokl, tmol;
  logic [31:0] idvl, tsvl;
  logic        acc_d1 = 1'b0, acc_d2 = 1'b0, adr_d1 = 1'b0, adr_d2 = 1'b0;
  always @(posedge clock) begin
    acc_d1 <= busl.read & ~busl.waitrequest;
    acc_d2 <= acc_d1;
    adr_d1 <= busl.address;
    adr_d2 <= adr_d1;
  end
  assign busl.waitrequest = 1'b0;
  assign busl.readdata    = acc_d2 ? (adr_d2 ? TS_GOOD : 32'h0) : GARBAGE;

  sysid_read_checker #(.READ_LATENCY(2)) ul (
    .clock(clock), .reset(reset), .start(startl), .avm(busl),
    .busy(busyl), .done(donel), .pass(passl), .id_ok(idokl), .ts_ok(tsokl),
    .timeout(tmol), .id_value(idvl), .ts_value(tsvl)
  );

  // Instance T: TIMEOUT_CYCLES=5, waitrequest stuck high.
  sysid_read_checker_if bust ();
  logic        startt = 1'b0;
  logic        busyt, donet, passt, idokt, tsokt, tmot;
  logic [31:0] idvt, tsvt;
  assign bust.waitrequest = 1'b1;
  assign bust.readdata    = GARBAGE;

  sysid_read_checker #(.TIMEOUT_CYCLES(5)) ut (
    .clock(clock), .reset(reset), .start(startt), .avm(bust),
    .busy(busyt), .done(donet), .pass(passt), .id_ok(idokt), .ts_ok(tsokt),
    .timeout(tmot), .id_value(idvt), .ts_value(tsvt)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_busy", {31'b0, busy0}, 32'd0);
    check("rst_done", {31'b0, done0}, 32'd0);
    check("rst_read", {31'b0, bus0.read}, 32'd0);
    check("rst_pass", {31'b0, pass0}, 32'd0);
    reset = 1'b0;
    tick();

    // Nominal read, zero latency, no stall
    start0 = 1'b1;
    tick();                                   // cycle 1
    start0 = 1'b0;
    check("t1_c1_read", {31'b0, bus0.read}, 32'd1);
    check("t1_c1_addr", {31'b0, bus0.address}, 32'd0);
    check("t1_c1_busy", {31'b0, busy0}, 32'd1);
    tick();                                   // cycle 2
    check("t1_c2_read", {31'b0, bus0.read}, 32'd1);
    check("t1_c2_addr", {31'b0, bus0.address}, 32'd1);
    tick();                                   // cycle 3
    check("t1_c3_read", {31'b0, bus0.read}, 32'd0);
    check("t1_c3_done", {31'b0, done0}, 32'd0);
    tick();                                   // cycle 4
    check("t1_c4_done", {31'b0, done0}, 32'd1);
    check("t1_c4_busy", {31'b0, busy0}, 32'd0);
    check("t1_pass", {31'b0, pass0}, 32'd1);
    check("t1_id_value", idv0, 32'h0);
    check("t1_ts_value", tsv0, TS_GOOD);
    tick();
    check("t1_hold_done", {31'b0, done0}, 32'd1);

    // Timestamp off by one
    ts_word0 = 32'h5923_F617;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("t2_done_clr", {31'b0, done0}, 32'd0);
    tick();
    tick();
    tick();
    check("t2_done", {31'b0, done0}, 32'd1);
    check("t2_id_ok", {31'b0, idok0}, 32'd1);
    check("t2_ts_ok", {31'b0, tsok0}, 32'd0);
    check("t2_pass", {31'b0, pass0}, 32'd0);
    check("t2_ts_value", tsv0, 32'h5923_F617);
    ts_word0 = TS_GOOD;

    // Three stall cycles on each read
    wr0 = 1'b1;
    start0 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start0 = 1'b0;
      wr0 = (c == 4 || c == 8) ? 1'b0 : 1'b1;
      if (c <= 4) begin
        check($sformatf("t3_c%0d_read", c), {31'b0, bus0.read}, 32'd1);
        check($sformatf("t3_c%0d_addr", c), {31'b0, bus0.address}, 32'd0);
      end else if (c <= 8) begin
        check($sformatf("t3_c%0d_read", c), {31'b0, bus0.read}, 32'd1);
        check($sformatf("t3_c%0d_addr", c), {31'b0, bus0.address}, 32'd1);
      end else begin
        check($sformatf("t3_c%0d_done", c), {31'b0, done0}, (c == 10) ? 32'd1 : 32'd0);
      end
    end
    check("t3_pass", {31'b0, pass0}, 32'd1);
    check("t3_ts_value", tsv0, TS_GOOD);
    wr0 = 1'b0;

    // READ_LATENCY=2 with garbage outside the data cycle
    startl = 1'b1;
    tick();                                   // cycle 1
    startl = 1'b0;
    check("t4_c1_read", {31'b0, busl.read}, 32'd1);
    tick();                                   // cycle 2
    check("t4_c2_read", {31'b0, busl.read}, 32'd0);
    tick();                                   // cycle 3
    tick();                                   // cycle 4
    check("t4_c4_read", {31'b0, busl.read}, 32'd1);
    check("t4_c4_addr", {31'b0, busl.address}, 32'd1);
    tick();
    tick();
    tick();                                   // cycle 7
    check("t4_c7_done", {31'b0, donel}, 32'd0);
    tick();                                   // cycle 8
    check("t4_c8_done", {31'b0, donel}, 32'd1);
    check("t4_pass", {31'b0, passl}, 32'd1);
    check("t4_id_value", idvl, 32'h0);
    check("t4_ts_value", tsvl, TS_GOOD);

    // Timeout with stuck waitrequest; extra start while busy
    startt = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      startt = (c == 3) ? 1'b1 : 1'b0;
      if (c <= 5) begin
        check($sformatf("t5_c%0d_read", c), {31'b0, bust.read}, 32'd1);
      end
    end
    check("t5_c6_read", {31'b0, bust.read}, 32'd0);
    check("t5_timeout", {31'b0, tmot}, 32'd1);
    check("t5_done", {31'b0, donet}, 32'd1);
    check("t5_busy", {31'b0, busyt}, 32'd0);
    check("t5_pass", {31'b0, passt}, 32'd0);
    check("t5_id_ok", {31'b0, idokt}, 32'd0);
    check("t5_id_value", idvt, 32'h0);
    tick();
    check("t5_c7_read", {31'b0, bust.read}, 32'd0);

    // Reset while reading the timestamp, reset beats start
    start0 = 1'b1;
    tick();                                   // cycle 1
    start0 = 1'b0;
    tick();                                   // cycle 2 (RD_TS)
    check("t6_c2_addr", {31'b0, bus0.address}, 32'd1);
    reset = 1'b1;
    tick();
    check("t6_rst_read", {31'b0, bus0.read}, 32'd0);
    check("t6_rst_busy", {31'b0, busy0}, 32'd0);
    check("t6_rst_done", {31'b0, done0}, 32'd0);
    check("t6_rst_ts", tsv0, 32'h0);
    check("t6_rst_id", idv0, 32'h0);
    start0 = 1'b1;
    tick();
    check("t6_rst_start_busy", {31'b0, busy0}, 32'd0);
    check("t6_rst_start_read", {31'b0, bus0.read}, 32'd0);
    reset = 1'b0;
    start0 = 1'b0;
    tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    tick();
    tick();
    check("t6_again_done", {31'b0, done0}, 32'd1);
    check("t6_again_pass", {31'b0, pass0}, 32'd1);
    check("t6_again_ts", tsv0, TS_GOOD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sysid_read_checker.md
Name: sysid_read_checker

Overview:
- Avalon-MM read master that forms the initiator end of the system-ID control slave.
- On a start pulse, it reads word 0 (system ID) and then word 1 (build timestamp).
- It compares both words against build-time expected values and reports pass/fail.
- It sits beside the Nios II boot logic, so hardware can refuse to release the CPU when the loaded image does not match the generated system.

Parameters:
- EXPECTED_ID, 32'h0000_0000, expected value at word address 0.
- EXPECTED_TIMESTAMP, 32'h5923_F616 (1495528982), expected value at word address 1.
- READ_LATENCY, 0, cycles from read acceptance to valid readdata; range 0..7. A value of 0 means data is sampled in the accept cycle.
- TIMEOUT_CYCLES, 255, maximum cycles per transaction (issue through capture) before abort; range 1..65535.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run a check.
- address  out  1  word address to the sysid slave.
- read  out  1  Avalon read strobe.
- waitrequest  in  1  slave stall; tie to 0 for the sysid slave.
- readdata  in  32  slave read data.
- busy  out  1  check in progress.
- done  out  1  level; high from check completion until the next accepted start.
- pass  out  1  valid when done: id_ok & ts_ok & !timeout.
- id_ok  out  1  captured ID equals EXPECTED_ID.
- ts_ok  out  1  captured timestamp equals EXPECTED_TIMESTAMP.
- timeout  out  1  a transaction exceeded TIMEOUT_CYCLES.
- id_value  out  32  captured word 0.
- ts_value  out  32  captured word 1.

Behaviour:
- Reset (synchronous, takes effect at the clock edge where reset=1): all outputs become 0, state becomes IDLE, counters clear. Reset mid-transaction drops read on that same edge; the partial result is discarded.
- States and transitions:
  - IDLE: on start=1, clear done/pass/id_ok/ts_ok/timeout/id_value/ts_value, set busy=1, go to RD_ID.
  - RD_ID: read=1, address=0. Held stable while waitrequest=1. The read is accepted on the cycle where read=1 and waitrequest=0.
    - On accept with READ_LATENCY=0: capture readdata into id_value that cycle, go to RD_TS.
    - On accept with READ_LATENCY>0: read=0 from the next cycle, go to LAT_ID.
  - LAT_ID: count READ_LATENCY cycles after accept. Capture readdata on the cycle that is exactly READ_LATENCY cycles after the accept cycle, then go to RD_TS.
  - RD_TS and LAT_TS: same as RD_ID and LAT_ID, but with address=1 and capture into ts_value.
  - CMP: one cycle. Register id_ok, ts_ok and pass; busy=0; done=1; go to DONE.
  - DONE: outputs hold. On start=1, behave exactly as IDLE.
- Addressing: address is 0 in RD_ID/LAT_ID and 1 in RD_TS/LAT_TS. In every other state address=0 and read=0.
- Latency: with waitrequest=0 and READ_LATENCY=0, start at cycle 0 gives done=1 visible at cycle 4 (RD_ID c1, RD_TS c2, CMP c3, DONE c4). Each latency cycle adds one cycle per word.
- Timeout:
  - A per-transaction counter clears on entry to RD_x and increments every cycle through LAT_x.
  - If it reaches TIMEOUT_CYCLES before capture: read=0 on the next cycle, timeout=1, id_ok/ts_ok left at 0, pass=0, go to DONE with busy=0.
  - A word that was not captured reads as 0.
- Simultaneous events:
  - start while busy=1 is ignored.
  - start together with reset: reset wins.
  - waitrequest deasserting on the same cycle the timeout count is reached: accept wins and the data is captured.
- Comparisons are exact 32-bit equality. No masking.
- readdata is ignored on every cycle other than the capture cycle.

Test Plan:
- Slave model returns 0 at address 0 and 1495528982 at address 1, waitrequest=0, READ_LATENCY=0; pulse start -> read high cycles 1-2 with address 0 then 1; done=1 at cycle 4; pass=1, id_value=0, ts_value=32'h5923_F616.
- Same, but slave returns 32'h5923_F617 at address 1 -> done=1, id_ok=1, ts_ok=0, pass=0, ts_value=32'h5923_F617.
- waitrequest held high 3 cycles on each read -> read and address stable while stalled; done at cycle 10; pass=1.
- READ_LATENCY=2, slave drives valid data only 2 cycles after accept and garbage 32'hDEAD_BEEF otherwise -> correct capture, pass=1; done at cycle 8.
- TIMEOUT_CYCLES=5, waitrequest stuck high -> read drops after 5 cycles in RD_ID; timeout=1, pass=0, id_value=0; a second start while busy is ignored.
- Assert reset while in RD_TS -> next cycle read=0, busy=0, done=0, all values 0; a subsequent start completes normally with pass=1.
